axis_shutdown_ctrl: RTL and testbench
=====================================

Name: axis_shutdown_ctrl

Overview:
- Central sequencer driving the shutdown_req inputs of up to C_NUM_CHANNELS axis_shutdown instances and collecting their shutdown_ack outputs.
- Turns one software-level stop request into a coordinated stop/restart of all selected stream channels.
- Provides an aggregate status, a per-channel timeout watchdog and a sticky stuck-channel mask for the register file.
- Sits upstream of the axis_shutdown stages on the control side and runs in their clock domain (their C_CDC_STAGES = 0).

Parameters:
- C_NUM_CHANNELS, 4, number of controlled channels (1..32).
- C_TIMEOUT_WIDTH, 16, width of the watchdog counter.
- C_TIMEOUT_CYCLES, 1024, cycles spent in STOPPING/STARTING before timeout is flagged; 0 disables the watchdog; must be < 2^C_TIMEOUT_WIDTH.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- stop_req  in  1  level; 1 = channels must be stopped, 0 = channels must run.
- channel_mask  in  C_NUM_CHANNELS  channels taking part; latched on entry to STOPPING.
- shutdown_req  out  C_NUM_CHANNELS  to the axis_shutdown shutdown_req inputs.
- shutdown_ack  in  C_NUM_CHANNELS  from the axis_shutdown shutdown_ack outputs.
- state  out  2  0=RUNNING, 1=STOPPING, 2=STOPPED, 3=STARTING.
- stopped  out  1  1 only in STOPPED.
- timeout  out  1  sticky; watchdog expired in the current STOPPING/STARTING phase.
- stuck_mask  out  C_NUM_CHANNELS  sticky; masked channels whose ack was wrong at timeout.

Behaviour:
- Reset: state=RUNNING, shutdown_req=0, mask_l=0, counter=0, stopped=0, timeout=0, stuck_mask=0. All outputs are registered.
- RUNNING:
  - On stop_req=1 sampled at edge N: latch mask_l=channel_mask, clear counter, timeout and stuck_mask.
  - From N+1: shutdown_req=mask_l and state=STOPPING.
- STOPPING:
  - If stop_req=0: go to STARTING and set shutdown_req=0. This abort has priority over completion.
  - Else, if (shutdown_ack & mask_l)==mask_l: go to STOPPED and set stopped=1. Both take effect one cycle after the ack is sampled.
  - mask_l=0 reaches STOPPED one cycle after entering STOPPING.
- STOPPED:
  - shutdown_req is held at mask_l.
  - On stop_req=0: go to STARTING, set shutdown_req=0 and stopped=0 on the next edge, and clear counter, timeout and stuck_mask.
- STARTING:
  - Wait for (shutdown_ack & mask_l)==0, then go to RUNNING.
  - A stop_req=1 during STARTING is not serviced until RUNNING is reached. RUNNING lasts at least one cycle, then STOPPING is entered.
- Watchdog:
  - The counter increments each cycle in STOPPING/STARTING and saturates; it clears on every state change.
  - When counter==C_TIMEOUT_CYCLES-1 and the phase is incomplete:
    - timeout=1.
    - STOPPING: stuck_mask=mask_l & ~shutdown_ack.
    - STARTING: stuck_mask=mask_l & shutdown_ack.
  - The FSM keeps waiting; timeout does not force a transition.
  - The flags clear only at the start of the next phase or on rst.
- Unmasked channels:
  - Their shutdown_req is always 0 and their acks are ignored.
  - channel_mask changes outside the RUNNING→STOPPING edge have no effect.
- Acks that deassert while STOPPED are not monitored; state stays STOPPED.
- rst mid-phase: all shutdown_req drop to 0 on the same edge; state=RUNNING.

Test Plan:
- mask=4'b1111, stop_req 0→1, acks rise 3,5,7,9 cycles later -> shutdown_req=4'hF one cycle after stop_req; STOPPED/stopped=1 one cycle after the 9-cycle ack; timeout=0.
- From STOPPED, stop_req=0, acks fall after 4 cycles -> shutdown_req=0 next cycle; state=3 for 5 cycles, then 0.
- mask=4'b0101, only acks 0 and 2 rise -> STOPPED reached; shutdown_req[1] and shutdown_req[3] stay 0 throughout.
- C_TIMEOUT_CYCLES=16, ack[2] never rises -> timeout=1 and stuck_mask=4'b0100 after 16 cycles in STOPPING; raising ack[2] later -> STOPPED, flags stay set.
- stop_req drops in STOPPING before all acks arrive -> STARTING next cycle, shutdown_req=0; RUNNING once acks clear.
- rst pulsed while in STOPPED -> next cycle shutdown_req=0, state=0, stopped=0, timeout=0.

Source files
------------

// File: rtl/axis_shutdown_ctrl_if.sv
// Channel-side bundle between the shutdown sequencer and its axis_shutdown stages.
// master: drives shutdown_req, observes shutdown_ack (the sequencer).
// slave : observes shutdown_req, drives shutdown_ack (the channel stages).
interface axis_shutdown_ctrl_if #(
    parameter int C_NUM_CHANNELS = 4
);
    logic [C_NUM_CHANNELS-1:0] shutdown_req;
    logic [C_NUM_CHANNELS-1:0] shutdown_ack;

    modport master (
        output shutdown_req,
        input  shutdown_ack
    );

    modport slave (
        input  shutdown_req,
        output shutdown_ack
    );
endinterface

// File: rtl/axis_shutdown_ctrl.sv
// Sequences a coordinated stop/restart of up to C_NUM_CHANNELS axis_shutdown channels.
// Latency: every output is registered; transitions appear one cycle after the causing input is sampled.
// Backpressure: none; waits on the channel acks indefinitely, and the watchdog only flags a late phase.
//
// Ports: clk/rst (sync, active-high); stop_req level request; channel_mask latched on entry
// to STOPPING; chan carries shutdown_req/shutdown_ack; state/stopped/timeout/stuck_mask status.
module axis_shutdown_ctrl #(
    parameter int C_NUM_CHANNELS   = 4,
    parameter int C_TIMEOUT_WIDTH  = 16,
    parameter int C_TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stop_req,
    input  logic [C_NUM_CHANNELS-1:0] channel_mask,
    axis_shutdown_ctrl_if.master      chan,
    output logic [1:0]                state,
    output logic                      stopped,
    output logic                      timeout,
    output logic [C_NUM_CHANNELS-1:0] stuck_mask
);

    typedef enum logic [1:0] {
        RUNNING  = 2'd0,
        STOPPING = 2'd1,
        STOPPED  = 2'd2,
        STARTING = 2'd3
    } state_t;

    localparam bit                   TO_EN   = (C_TIMEOUT_CYCLES != 0);
    localparam logic [C_TIMEOUT_WIDTH-1:0] TO_LAST =
        C_TIMEOUT_WIDTH'(C_TIMEOUT_CYCLES - 1);
    localparam logic [C_TIMEOUT_WIDTH-1:0] CNT_MAX = '1;

    state_t                      st;
    logic [C_NUM_CHANNELS-1:0]   mask_l;
    logic [C_TIMEOUT_WIDTH-1:0]  counter;

    logic [C_NUM_CHANNELS-1:0]   ack_m;
    logic                        acks_set;
    logic                        acks_clear;
    logic                        wd_fire;
    logic [C_TIMEOUT_WIDTH-1:0]  counter_inc;

    // Only latched channels are looked at; unmasked acks never influence the sequence.
    assign ack_m       = chan.shutdown_ack & mask_l;
    assign acks_set    = (ack_m == mask_l);
    assign acks_clear  = (ack_m == '0);
    assign wd_fire     = TO_EN && (counter == TO_LAST);
    assign counter_inc = (counter == CNT_MAX) ? counter : counter + 1'b1;

    assign state = st;

    always_ff @(posedge clk) begin
        if (rst) begin
            st                <= RUNNING;
            chan.shutdown_req <= '0;
            mask_l            <= '0;
            counter           <= '0;
            stopped           <= 1'b0;
            timeout           <= 1'b0;
            stuck_mask        <= '0;
        end else begin
            case (st)
                RUNNING: begin
                    if (stop_req) begin
                        st                <= STOPPING;
                        mask_l            <= channel_mask;
                        chan.shutdown_req <= channel_mask;
                        counter           <= '0;
                        timeout           <= 1'b0;
                        stuck_mask        <= '0;
                    end
                end

                STOPPING: begin
                    // Abort wins over completion so a released request never parks in STOPPED.
                    if (!stop_req) begin
                        st                <= STARTING;
                        chan.shutdown_req <= '0;
                        counter           <= '0;
                        timeout           <= 1'b0;
                        stuck_mask        <= '0;
                    end else if (acks_set) begin
                        st      <= STOPPED;
                        stopped <= 1'b1;
                        counter <= '0;
                    end else begin
                        counter <= counter_inc;
                        if (wd_fire) begin
                            timeout    <= 1'b1;
                            stuck_mask <= mask_l & ~chan.shutdown_ack;
                        end
                    end
                end

                STOPPED: begin
                    // Acks are not monitored here; only the release of stop_req matters.
                    if (!stop_req) begin
                        st                <= STARTING;
                        chan.shutdown_req <= '0;
                        stopped           <= 1'b0;
                        counter           <= '0;
                        timeout           <= 1'b0;
                        stuck_mask        <= '0;
                    end
                end

                STARTING: begin
                    // A pending stop_req is deliberately ignored until RUNNING is reached.
                    if (acks_clear) begin
                        st      <= RUNNING;
                        counter <= '0;
                    end else begin
                        counter <= counter_inc;
                        if (wd_fire) begin
                            timeout    <= 1'b1;
                            stuck_mask <= mask_l & chan.shutdown_ack;
                        end
                    end
                end

                default: st <= RUNNING;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_shutdown_ctrl.sv
module tb_axis_shutdown_ctrl;

    localparam int NCH  = 4;
    localparam int TOW  = 8;
    localparam int TOC  = 16;
    localparam int NCYC = 4000;

    localparam int P_RUN  = 0;
    localparam int P_STOP = 1;
    localparam int P_HALT = 2;
    localparam int P_GO   = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           stop_req = 1'b0;
    logic [NCH-1:0] channel_mask = '0;
    logic [1:0]     state;
    logic           stopped;
    logic           timeout;
    logic [NCH-1:0] stuck_mask;

    axis_shutdown_ctrl_if #(.C_NUM_CHANNELS(NCH)) chan ();

    axis_shutdown_ctrl #(
        .C_NUM_CHANNELS   (NCH),
        .C_TIMEOUT_WIDTH  (TOW),
        .C_TIMEOUT_CYCLES (TOC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stop_req     (stop_req),
        .channel_mask (channel_mask),
        .chan         (chan),
        .state        (state),
        .stopped      (stopped),
        .timeout      (timeout),
        .stuck_mask   (stuck_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]     st;
        logic [NCH-1:0] req;
        logic           stp;
        logic           to;
        logic [NCH-1:0] stuck;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: phase plus number of cycles already spent in it.
    int             m_phase = P_RUN;
    int             m_age   = 0;
    logic [NCH-1:0] m_mask  = '0;
    logic [NCH-1:0] m_req   = '0;
    logic           m_stp   = 1'b0;
    logic           m_to    = 1'b0;
    logic [NCH-1:0] m_stuck = '0;

    logic [NCH-1:0] ack_r = '0;
    int             dly [NCH];

    assign chan.shutdown_ack = ack_r;

    task automatic new_phase(input int ph);
        m_phase = ph;
        m_age   = 0;
        if (ph == P_STOP || ph == P_GO) begin
            m_to    = 1'b0;
            m_stuck = '0;
        end
    endtask

    task automatic model_step();
        logic [NCH-1:0] seen;
        seen = ack_r & m_mask;
        if (rst) begin
            m_phase = P_RUN; m_age = 0; m_mask = '0; m_req = '0;
            m_stp = 1'b0; m_to = 1'b0; m_stuck = '0;
        end else if (m_phase == P_RUN) begin
            if (stop_req) begin
                m_mask = channel_mask;
                m_req  = channel_mask;
                new_phase(P_STOP);
            end
        end else if (m_phase == P_STOP) begin
            if (!stop_req) begin
                m_req = '0;
                new_phase(P_GO);
            end else if (seen == m_mask) begin
                m_stp = 1'b1;
                new_phase(P_HALT);
            end else begin
                m_age++;
                if (m_age == TOC) begin
                    m_to    = 1'b1;
                    m_stuck = m_mask & ~ack_r;
                end
            end
        end else if (m_phase == P_HALT) begin
            if (!stop_req) begin
                m_req = '0;
                m_stp = 1'b0;
                new_phase(P_GO);
            end
        end else begin
            if (seen == '0) begin
                new_phase(P_RUN);
            end else begin
                m_age++;
                if (m_age == TOC) begin
                    m_to    = 1'b1;
                    m_stuck = m_mask & ack_r;
                end
            end
        end
    endtask

    function automatic int pick_delay();
        // Occasionally a channel is much slower than the watchdog window.
        if ($urandom_range(0, 6) == 0) return $urandom_range(TOC + 2, 40);
        return $urandom_range(0, 6);
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        if (act != exp_v) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Monitor: outputs are compared every cycle, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_vec++;
                chk("state",        int'(state),             int'(e.st));
                chk("shutdown_req", int'(chan.shutdown_req), int'(e.req));
                chk("stopped",      int'(stopped),           int'(e.stp));
                chk("timeout",      int'(timeout),           int'(e.to));
                chk("stuck_mask",   int'(stuck_mask),        int'(e.stuck));
            end
        end
    end

    // Driver: channel stages emulated as ack followers with random latency.
    initial begin
        int   hold;
        exp_t e;
        logic [NCH-1:0] obs_req;
        hold = 5;
        for (int i = 0; i < NCH; i++) dly[i] = 0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            rst = (cyc < 2) || ($urandom_range(0, 299) == 0);

            if (hold == 0) begin
                stop_req = ~stop_req;
                hold     = $urandom_range(3, 50);
            end else begin
                hold--;
            end
            channel_mask = NCH'($urandom_range(0, (1 << NCH) - 1));

            obs_req = chan.shutdown_req;
            for (int i = 0; i < NCH; i++) begin
                if (!m_mask[i]) begin
                    if ($urandom_range(0, 3) == 0) ack_r[i] = ~ack_r[i];
                end else if (m_phase == P_HALT && $urandom_range(0, 19) == 0) begin
                    ack_r[i] = 1'b0;
                end else if (ack_r[i] == obs_req[i]) begin
                    dly[i] = pick_delay();
                end else if (dly[i] == 0) begin
                    ack_r[i] = obs_req[i];
                end else begin
                    dly[i]--;
                end
            end

            model_step();
            e.st    = 2'(m_phase);
            e.req   = m_req;
            e.stp   = m_stp;
            e.to    = m_to;
            e.stuck = m_stuck;
            sb.push_back(e);
        end

        @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
